// File: rtl/wallace_mul_pkg.sv
// Shared constants and state encoding for the wallace_mul_sched scheduler.
package wallace_mul_pkg;

  localparam int NUM_REQ    = 2;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_SETTLE = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wallace_mul_rr_arb.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is granted.
module wallace_mul_rr_arb
  import wallace_mul_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic               last_grant_i,
  input  logic               enable_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               grant_idx_o
);

  always_comb begin
    grant_o     = '0;
    grant_idx_o = (req_valid_i == 2'b11) ? ~last_grant_i : req_valid_i[1];
    if (enable_i && req_valid_i[grant_idx_o]) begin
      grant_o[grant_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/wallace_mul_tree.sv
// Combinational unsigned Wallace-tree multiplier: 3:2 row compression (FA/HA) then a PG ripple adder.
module wallace_mul_tree #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] p_o
);

  localparam int PW = 2 * WIDTH;
  localparam int NR = WIDTH + 3;

  logic [PW-1:0] rows [NR];
  logic [PW-1:0] nxt  [NR];
  logic [PW-1:0] gen, prop, carry;
  int            cnt, ncnt;

  // Rows stay non-negative and sum to the product, so the carry row's dropped MSB is always zero.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      rows[i] = '0;
      nxt[i]  = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      rows[i] = PW'(a_i & {WIDTH{b_i[i]}}) << i;
    end
    cnt  = WIDTH;
    ncnt = 0;
    for (int lvl = 0; lvl < WIDTH; lvl++) begin
      ncnt = 0;
      for (int i = 0; i < NR; i++) begin
        nxt[i] = '0;
      end
      for (int r = 0; r < WIDTH; r += 3) begin
        if (r + 2 < cnt) begin
          nxt[ncnt]     = rows[r] ^ rows[r+1] ^ rows[r+2];
          nxt[ncnt + 1] = ((rows[r] & rows[r+1]) | (rows[r] & rows[r+2]) |
                           (rows[r+1] & rows[r+2])) << 1;
          ncnt += 2;
        end else begin
          if (r < cnt) begin
            nxt[ncnt] = rows[r];
            ncnt += 1;
          end
          if (r + 1 < cnt) begin
            nxt[ncnt] = rows[r+1];
            ncnt += 1;
          end
        end
      end
      if (cnt > 2) begin
        rows = nxt;
        cnt  = ncnt;
      end
    end

    gen      = rows[0] & rows[1];
    prop     = rows[0] ^ rows[1];
    carry    = '0;
    for (int i = 0; i < PW - 1; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
    p_o = prop ^ carry;
  end

endmodule

// File: rtl/wallace_mul_sched.sv
// Round-robin scheduler sharing one multicycle Wallace multiplier between two requesters.
// Optional perf counters enabled by defining WALLACE_MUL_SCHED_PERF_EN.
module wallace_mul_sched
  import wallace_mul_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [2*WIDTH-1:0]         res_product,
  output logic                       res_id,
  output logic                       busy
`ifdef WALLACE_MUL_SCHED_PERF_EN
  , output logic [15:0]              op_count
  , output logic [NUM_REQ-1:0]       grant_hist
`endif
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic                 gid_q, gid_d;
  logic                 last_q, last_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 rid_q, rid_d;
  logic                 rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0]   grant;
  logic                 gidx;
  logic                 accept;
  logic [2*WIDTH-1:0]   mul_p;

  wallace_mul_rr_arb u_arb (
    .req_valid_i  (req_valid),
    .last_grant_i (last_q),
    .enable_i     (state_q == IDLE),
    .grant_o      (grant),
    .grant_idx_o  (gidx)
  );

  wallace_mul_tree #(.WIDTH(WIDTH)) u_tree (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (mul_p)
  );

  assign accept = |grant;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    gid_d    = gid_q;
    last_d   = last_q;
    prod_d   = prod_q;
    rid_d    = rid_q;
    rvalid_d = rvalid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = gidx ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
          b_d     = gidx ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
          gid_d   = gidx;
          last_d  = gidx;
          cnt_d   = SETTLE_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Operands have been stable for SETTLE edges once the counter reaches zero.
        if (cnt_q == 4'd0) begin
          prod_d   = mul_p;
          rid_d    = gid_q;
          rvalid_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (res_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      gid_q    <= 1'b0;
      last_q   <= 1'b1;
      prod_q   <= '0;
      rid_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gid_q    <= gid_d;
      last_q   <= last_d;
      prod_q   <= prod_d;
      rid_q    <= rid_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign req_ready   = grant;
  assign res_valid   = rvalid_q;
  assign res_product = prod_q;
  assign res_id      = rid_q;
  assign busy        = (state_q != IDLE);

`ifdef WALLACE_MUL_SCHED_PERF_EN
  logic [15:0]        ops_q;
  logic [NUM_REQ-1:0] hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q  <= '0;
      hist_q <= '0;
    end else begin
      if (rvalid_q && res_ready) begin
        ops_q <= ops_q + 16'd1;
      end
      hist_q <= hist_q | grant;
    end
  end

  assign op_count   = ops_q;
  assign grant_hist = hist_q;
`endif

endmodule

// File: tb/tb_wallace_mul_sched.sv
// Randomized self-checking bench for wallace_mul_sched against a transaction-level timing model.
module tb_wallace_mul_sched;

  localparam int W      = 8;
  localparam int SETTLE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    reqValid = '0;
  logic [1:0]    reqReady;
  logic [2*W-1:0] reqA = '0, reqB = '0;
  logic          resValid;
  logic          resReady = 1'b0;
  logic [2*W-1:0] resProduct;
  logic          resId;
  logic          busy;
`ifdef WALLACE_MUL_SCHED_PERF_EN
  logic [15:0]   opCount;
  logic [1:0]    grantHist;
  logic [15:0]   s1OpCount;
  logic [1:0]    s1GrantHist;
`endif

  logic          s1Rst = 1'b1;
  logic [1:0]    s1ReqValid = '0;
  logic [1:0]    s1ReqReady;
  logic [2*W-1:0] s1ReqA = '0, s1ReqB = '0;
  logic          s1ResValid;
  logic [2*W-1:0] s1ResProduct;
  logic          s1ResId;
  logic          s1Busy;

  int assertCount = 0;
  int failCount   = 0;

  // Model: transaction-level view of the scheduler's externally visible behaviour.
  logic        mBusy, mValid, mLast, mOutId, mPendId;
  int          mAge, mPendProd, mOutProd;
  int          mOps;
  logic [1:0]  mHist;

  wallace_mul_sched #(.WIDTH(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady),
    .req_a(reqA), .req_b(reqB), .res_valid(resValid), .res_ready(resReady),
    .res_product(resProduct), .res_id(resId), .busy(busy)
`ifdef WALLACE_MUL_SCHED_PERF_EN
    , .op_count(opCount), .grant_hist(grantHist)
`endif
  );

  wallace_mul_sched #(.WIDTH(W), .SETTLE(1)) dutS1 (
    .clk(clk), .rst(s1Rst), .req_valid(s1ReqValid), .req_ready(s1ReqReady),
    .req_a(s1ReqA), .req_b(s1ReqB), .res_valid(s1ResValid), .res_ready(1'b1),
    .res_product(s1ResProduct), .res_id(s1ResId), .busy(s1Busy)
`ifdef WALLACE_MUL_SCHED_PERF_EN
    , .op_count(s1OpCount), .grant_hist(s1GrantHist)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic pickGrant(input logic [1:0] rv, input logic last);
    if (rv == 2'b11) return ~last;
    return rv[1];
  endfunction

  task automatic applyStimulus(input logic [1:0] rv, input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic [W-1:0] a1, input logic [W-1:0] b1,
                               input logic rr, input logic r);
    logic       g;
    logic [1:0] expReady;
    @(negedge clk);
    rst = r; reqValid = rv; reqA = {a1, a0}; reqB = {b1, b0}; resReady = rr;
    #1;
    g        = pickGrant(rv, mLast);
    expReady = (!mBusy && rv != 2'b00) ? (2'b01 << g) : 2'b00;
    checkOutput("req_ready", reqReady, expReady);
    checkOutput("res_valid", resValid, mValid);
    checkOutput("busy", busy, mBusy);
    checkOutput("res_product", resProduct, mOutProd);
    checkOutput("res_id", resId, mOutId);
`ifdef WALLACE_MUL_SCHED_PERF_EN
    checkOutput("op_count", opCount, mOps);
    checkOutput("grant_hist", grantHist, mHist);
`endif
    @(posedge clk);
    if (r) begin
      mBusy = 0; mValid = 0; mOutProd = 0; mOutId = 0; mLast = 1; mOps = 0; mHist = 0;
    end else if (!mBusy) begin
      if (rv != 2'b00) begin
        mPendProd = g ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
        mPendId = g; mLast = g; mAge = 0; mBusy = 1; mHist[g] = 1'b1;
      end
    end else if (!mValid) begin
      mAge++;
      if (mAge == SETTLE) begin
        mValid = 1; mOutProd = mPendProd; mOutId = mPendId;
      end
    end else if (rr) begin
      mValid = 0; mBusy = 0; mOps = (mOps + 1) % 65536;
    end
  endtask

  function automatic logic [W-1:0] randOperand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    mBusy = 0; mValid = 0; mLast = 1; mOutId = 0; mPendId = 0;
    mAge = 0; mPendProd = 0; mOutProd = 0; mOps = 0; mHist = 0;

    $display("[TB] reset and 13*11 from requester 0");
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b0, 1'b1);
    applyStimulus(2'b01, 8'd13, 8'd11, 0, 0, 1'b0, 1'b0);
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    #1;
    checkOutput("plan1_valid", resValid, 1);
    checkOutput("plan1_product", resProduct, 143);
    checkOutput("plan1_id", resId, 0);
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);

    $display("[TB] zero operand");
    applyStimulus(2'b01, 8'd0, 8'd200, 0, 0, 1'b0, 1'b0);
    applyStimulus(2'b01, 8'd5, 8'd5, 0, 0, 1'b0, 1'b0);
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    #1;
    checkOutput("zero_product", resProduct, 0);
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);

    $display("[TB] both requesters valid from reset");
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(2'b11, 8'd3, 8'd4, 8'd255, 8'd255, 1'b1, 1'b0);
      if (i == 3) begin
        #1;
        checkOutput("plan2_first", resProduct, 12);
        checkOutput("plan2_first_id", resId, 0);
      end
      if (i == 7) begin
        #1;
        checkOutput("plan2_second", resProduct, 65025);
        checkOutput("plan2_second_id", resId, 1);
      end
    end
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);

    $display("[TB] hold in DONE, then reset while waiting");
    applyStimulus(2'b10, 0, 0, 8'd20, 8'd30, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(2'b11, 8'd1, 8'd1, 8'd9, 8'd9, 1'b0, 1'b0);
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    applyStimulus(2'b01, 8'd7, 8'd9, 0, 0, 1'b0, 1'b0);
    applyStimulus(2'b00, 0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    #1;
    checkOutput("rst_wait_product", resProduct, 0);
    checkOutput("rst_wait_valid", resValid, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(2'($urandom), randOperand(), randOperand(), randOperand(), randOperand(),
                    1'($urandom), ($urandom_range(0, 99) == 0));
    end

    $display("[TB] SETTLE=1 instance");
    @(negedge clk); s1Rst = 1'b1;
    @(negedge clk); s1Rst = 1'b0; s1ReqValid = 2'b01; s1ReqA = {8'd0, 8'd1}; s1ReqB = {8'd0, 8'd255};
    #1;
    checkOutput("s1_ready", s1ReqReady, 2'b01);
    @(posedge clk); #1;
    s1ReqValid = 2'b00;
    checkOutput("s1_not_yet", s1ResValid, 0);
    @(posedge clk); #1;
    checkOutput("s1_valid", s1ResValid, 1);
    checkOutput("s1_product", s1ResProduct, 255);
    checkOutput("s1_busy", s1Busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/wallace_mul_sched.md
Name: wallace_mul_sched

Overview:
- Shares one combinational Wallace-tree multiplier (HA/FA/PG cells) between two requesters.
- Arbitrates round-robin and registers the operands.
- Holds the operands stable for a fixed number of settle cycles (a multicycle path through the tree), then captures the product.
- Returns the product with the requester ID over a valid/ready handshake. Sits between the requesting datapath blocks and the multiplier instance.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH.
- SETTLE, 2, cycles the registered operands are held before product capture; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_a  in  2*WIDTH  operand A; slice [i*WIDTH +: WIDTH] = requester i.
- req_b  in  2*WIDTH  operand B; same slicing.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_product  out  2*WIDTH  unsigned product a*b.
- res_id  out  1  requester index that owns res_product.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; res_valid=0, res_product=0, res_id=0, busy=0.
  - Operand regs =0; settle counter =0; last_grant=1, so requester 0 wins the first tie.
- IDLE:
  - grant = requester with valid set. If both are set, grant the one != last_grant.
  - req_ready[grant]=1 combinationally, only while in IDLE and req_valid[grant]=1; all other req_ready bits are 0.
  - On an accept edge (req_valid[g] & req_ready[g]): latch a, b, g; set last_grant=g; load counter=SETTLE-1; go to WAIT.
- WAIT:
  - Operand regs drive the multiplier unchanged.
  - Counter decrements each edge. The edge at which counter==0 captures the multiplier output into res_product and g into res_id, sets res_valid=1, and moves to DONE.
- DONE:
  - res_valid=1; res_product and res_id are stable.
  - On an edge with res_ready=1: res_valid=0, go to IDLE.
  - No new request is accepted in DONE or WAIT; req_ready=0.
- Latency: accept at edge k means res_valid is high after edge k+SETTLE.
  - With a same-cycle res_ready, the next accept is possible at edge k+SETTLE+2.
- Arithmetic: unsigned only; full 2*WIDTH result; no truncation or overflow.
- Boundary conditions:
  - req_valid dropped before it is accepted: no effect.
  - Operand changes on the request bus after accept: ignored.
  - res_ready held high while idle: ignored.
  - rst asserted in WAIT or DONE: the pending operation is discarded and is never presented, and all outputs take their reset values on the next edge.
  - SETTLE=1: capture happens on the first edge after accept.

Optional Feature:
- Macro: WALLACE_MUL_SCHED_PERF_EN.
- When defined:
  - Adds output port op_count (16 bits, reset 0).
  - op_count increments on each result handshake (res_valid & res_ready) and wraps from 0xFFFF to 0.
  - Adds output grant_hist (2 bits): one sticky bit per requester, set on accept, cleared by rst.
- When undefined: neither port nor the counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package wallace_mul_pkg holds:
  - the state encoding constants: IDLE=2'd0, WAIT=2'd1, DONE=2'd2;
  - NUM_REQ=2;
  - the default WIDTH and SETTLE.
- Natural sub-module: wallace_mul_rr_arb, the 2-way round-robin arbiter.
  - Inputs: req_valid, last_grant, enable (=state IDLE).
  - Outputs: one-hot grant, grant index.
- The Wallace multiplier is the existing tree instance, fed from the operand registers.

Test Plan:
1. After reset, req_valid=01, a0=13, b0=11 -> req_ready=01 for one cycle; with SETTLE=2, res_valid rises 2 edges after accept; res_product=143, res_id=0.
2. Both valid from reset: a0=3, b0=4; a1=255, b1=255; res_ready=1 -> first result 12 with id 0, second result 65025 with id 1; req_ready never 11.
3. Hold res_ready=0 for 5 cycles in DONE -> res_valid, res_product and res_id stay stable; req_ready=00; busy=1. Then res_ready=1 -> IDLE next edge.
4. Assert rst on the edge after accepting a=7, b=9 (state WAIT) -> next cycle res_valid=0, busy=0, res_product=0; the 63 result never appears.
5. Edge operands: a=0, b=200 -> 0; with SETTLE=1, a=1, b=255 -> 255 captured 1 edge after accept.
6. With WALLACE_MUL_SCHED_PERF_EN: four completed ops alternating requesters -> op_count=4, grant_hist=11. Preload via 65536 handshakes -> op_count wraps to 0.
